// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: time-multiplexed FIR inner product.
// A regressor/weight vector pair is captured on accept, then LANES taps per
// cycle are rounded, summed into a wide accumulator, and the saturated result
// is presented on a valid/ready output port.
module fir_tap_sequencer #(
    parameter int WIDTH = 16,
    parameter int QP    = 12,
    parameter int ORD   = 64,
    parameter int LANES = 4,
    parameter int SHIFT = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ORD*WIDTH-1:0]   filter_in_packed,
    input  logic [ORD*WIDTH-1:0]   weight_in_packed,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   busy
);

    localparam int N  = ORD / LANES;
    localparam int AW = WIDTH + $clog2(ORD);
    localparam int PW = 2 * WIDTH;
    localparam int RS = QP + SHIFT;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [IW-1:0]        LAST_IDX = IW'(N - 1);
    localparam logic signed [PW-1:0] RND      = PW'(1) << (RS - 1);
    localparam logic signed [AW-1:0] MAXV     = AW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [AW-1:0] MINV     = ~MAXV;

    generate
        if (ORD % LANES != 0) begin : g_bad_lanes
            $error("fir_tap_sequencer: ORD must be a multiple of LANES");
        end
        if (RS < 1) begin : g_bad_shift
            $error("fir_tap_sequencer: QP + SHIFT must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [ORD*WIDTH-1:0]    x_q;
    logic [ORD*WIDTH-1:0]    w_q;
    logic signed [AW-1:0]    acc_q;
    logic [IW-1:0]           idx_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [WIDTH-1:0]        out_data_q;
    logic                    busy_q;

    logic signed [PW-1:0]    prod  [LANES];
    logic signed [WIDTH-1:0] tap   [LANES];
    logic signed [AW-1:0]    grp_d;
    logic signed [AW-1:0]    acc_d;
    logic [WIDTH-1:0]        sat_d;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

    // Round each lane product, sum the group, and saturate the running total.
    // The captured vectors shift down by one group per RUN cycle, so the
    // current group always sits in the low LANES*WIDTH bits.
    always_comb begin
        grp_d = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            prod[j] = $signed(x_q[j*WIDTH +: WIDTH]) * $signed(w_q[j*WIDTH +: WIDTH]);
            tap[j]  = WIDTH'((prod[j] + RND) >>> RS);
            grp_d   = grp_d + AW'(tap[j]);
        end
        acc_d = acc_q + grp_d;
        if (acc_d > MAXV) begin
            sat_d = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (acc_d < MINV) begin
            sat_d = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            sat_d = acc_d[WIDTH-1:0];
        end
    end

    // Control FSM with registered handshake outputs and datapath state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            w_q         <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else if (clear) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        x_q        <= filter_in_packed;
                        w_q        <= weight_in_packed;
                        acc_q      <= '0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    x_q   <= x_q >> (LANES * WIDTH);
                    w_q   <= w_q >> (LANES * WIDTH);
                    idx_q <= idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
                        out_data_q  <= sat_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
